// File: rtl/fpga_loader_pkg.sv
// Shared types for the program loader: FSM state encoding and error codes
// reported on error_code.
package fpga_loader_pkg;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    START,
    RUN,
    ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_COUNT    = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;

endpackage

// File: rtl/fpga_word_assembler.sv
// Collects bytes little-endian into a BYTES-wide word and presents the
// finished word with a one-cycle word_valid pulse the cycle after its last byte.
module fpga_word_assembler #(
  parameter int BYTES = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               accept,
  input  logic [7:0]         data,
  output logic               last_lane,
  output logic               word_valid,
  output logic [8*BYTES-1:0] word
);

  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [IW-1:0]      byte_index;
  logic [8*BYTES-1:0] lanes;
  logic [8*BYTES-1:0] merged;

  assign last_lane = (byte_index == IW'(BYTES - 1));

  // Current lanes with the incoming byte dropped into its slot.
  always_comb begin
    merged = lanes;
    merged[8*int'(byte_index) +: 8] = data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_index <= '0;
      lanes      <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else if (clear) begin
      byte_index <= '0;
      lanes      <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (accept) begin
        lanes <= merged;
        if (last_lane) begin
          byte_index <= '0;
          word_valid <= 1'b1;
          word       <= merged;
        end else begin
          byte_index <= byte_index + IW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/fpga_program_loader.sv
// Streams a framed program (count, little-endian words, XOR checksum) into the
// executor's instruction memory, then starts the executor and waits for done.
module fpga_program_loader
  import fpga_loader_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  output logic                   run_start,
  input  logic                   run_done,
  output logic                   busy,
  output logic                   error,
  output logic [1:0]             error_code,
  output logic [ADDR_WIDTH:0]    loaded_count
);

  localparam int          BYTES   = INSTR_WIDTH / 8;
  localparam int          DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t state, state_n;

  logic [7:0]          count_lo;
  logic [ADDR_WIDTH:0] count_r;
  logic [ADDR_WIDTH:0] word_index;
  logic [7:0]          csum;
  logic [15:0]         count_full;
  logic                accept;
  logic                data_accept;
  logic                last_lane;
  logic                word_done;
  logic                last_word;
  logic                count_too_big;
  logic                asm_clear;

  // Handshake: a byte transfers on a posedge where in_valid && in_ready.
  assign accept        = in_valid && in_ready;
  assign count_full    = {in_data, count_lo};
  assign count_too_big = ({1'b0, count_full} > DEPTH_L);
  assign data_accept   = accept && (state == DATA);
  assign word_done     = data_accept && last_lane;
  // word_index is one bit wider than mem_addr so a full-memory frame terminates.
  assign last_word     = ((word_index + (ADDR_WIDTH+1)'(1)) == count_r);
  assign asm_clear     = accept && (state == LEN_HI);

  fpga_word_assembler #(
    .BYTES (BYTES)
  ) u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (asm_clear),
    .accept     (data_accept),
    .data       (in_data),
    .last_lane  (last_lane),
    .word_valid (mem_we),
    .word       (mem_wdata)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= LEN_LO;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    run_start = 1'b0;
    error     = 1'b0;
    case (state)
      LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (accept) state_n = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        if (accept) begin
          if (count_too_big)           state_n = ERROR;
          else if (count_full == 16'd0) state_n = CHECK;
          else                          state_n = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (word_done && last_word) state_n = CHECK;
      end
      CHECK: begin
        in_ready = 1'b1;
        if (accept) state_n = (in_data == csum) ? START : ERROR;
      end
      START: begin
        run_start = 1'b1;
        state_n   = RUN;
      end
      RUN: begin
        if (run_done) state_n = LEN_LO;
      end
      ERROR: begin
        error = 1'b1;
      end
      default: state_n = LEN_LO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_lo     <= '0;
      count_r      <= '0;
      word_index   <= '0;
      csum         <= '0;
      mem_addr     <= '0;
      error_code   <= ERR_NONE;
      loaded_count <= '0;
    end else begin
      // The checksum byte itself is compared, never folded in.
      if (accept && (state != CHECK)) csum <= csum ^ in_data;
      case (state)
        LEN_LO: begin
          if (accept) count_lo <= in_data;
        end
        LEN_HI: begin
          if (accept) begin
            count_r    <= count_full[ADDR_WIDTH:0];
            word_index <= '0;
            if (count_too_big) error_code <= ERR_COUNT;
          end
        end
        DATA: begin
          if (word_done) begin
            mem_addr   <= word_index[ADDR_WIDTH-1:0];
            word_index <= word_index + (ADDR_WIDTH+1)'(1);
          end
        end
        CHECK: begin
          if (accept) begin
            if (in_data == csum) loaded_count <= count_r;
            else                 error_code   <= ERR_CHECKSUM;
          end
        end
        RUN: begin
          if (run_done) csum <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_program_loader.sv
// Self-checking bench for fpga_program_loader: frames are built and predicted
// from the frame format rules, and memory writes are scored in order.
module tb_fpga_program_loader;
  import fpga_loader_pkg::*;

  localparam int IW    = 32;
  localparam int AW    = 8;
  localparam int BYTES = IW / 8;
  localparam int DEPTH = 2 ** AW;
  localparam int W     = AW + IW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          run_done = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_wdata;
  logic          run_start;
  logic          busy;
  logic          error;
  logic [1:0]    error_code;
  logic [AW:0]   loaded_count;

  int checks = 0;
  int failures = 0;
  int run_start_cnt = 0;
  int rs_before;
  int exp_cnt;
  int exp_loaded = 0;
  bit exp_ok;
  logic [1:0] exp_err;

  logic [W-1:0]  exp_q[$];
  logic [7:0]    frame_q[$];
  logic [IW-1:0] words[$];
  logic [W-1:0]  mon_e;

  fpga_program_loader #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .run_start    (run_start),
    .run_done     (run_done),
    .busy         (busy),
    .error        (error),
    .error_code   (error_code),
    .loaded_count (loaded_count)
  );

  // Clock / reset
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every write must match the next predicted write.
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write got addr=%0h data=%08h expected none", mem_addr, mem_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          if ({mem_addr, mem_wdata} !== mon_e) begin
            failures++;
            $display("FAIL write got addr=%0h data=%08h expected addr=%0h data=%08h",
                     mem_addr, mem_wdata, mon_e[W-1:IW], mon_e[IW-1:0]);
          end
        end
      end
      if (run_start) begin
        run_start_cnt++;
        checks++;
        if (mem_we) begin
          failures++;
          $display("FAIL we_start_overlap got mem_we=1 run_start=1 expected not both");
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    run_done = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    exp_loaded = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout got in_ready=%b expected 1", in_ready);
      in_valid = 1'b0;
    end else begin
      tick();
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  // Reference model: builds the byte frame and predicts writes and outcome.
  task automatic build_frame(input int cnt, input bit bad, input logic [7:0] bad_val);
    logic [15:0]   c16;
    logic [7:0]    cs;
    logic [IW-1:0] w;
    c16 = 16'(cnt);
    frame_q.delete();
    frame_q.push_back(c16[7:0]);
    frame_q.push_back(c16[15:8]);
    rs_before = run_start_cnt;
    exp_cnt = cnt;
    if (cnt > DEPTH) begin
      exp_ok  = 1'b0;
      exp_err = ERR_COUNT;
    end else begin
      for (int i = 0; i < cnt; i++) begin
        w = words[i];
        for (int l = 0; l < BYTES; l++) frame_q.push_back(w[8*l +: 8]);
        exp_q.push_back({AW'(i), w});
      end
      cs = 8'h00;
      foreach (frame_q[k]) cs ^= frame_q[k];
      frame_q.push_back(bad ? bad_val : cs);
      exp_ok  = !bad || (bad_val == cs);
      exp_err = exp_ok ? ERR_NONE : ERR_CHECKSUM;
    end
  endtask

  task automatic send_frame(input bit gaps);
    foreach (frame_q[k]) send_byte(frame_q[k], gaps);
  endtask

  task automatic finish_frame();
    int guard;
    if (exp_ok) begin
      guard = 0;
      while (run_start_cnt == rs_before && guard < 20) begin
        tick();
        guard++;
      end
      checks++;
      if (run_start_cnt != rs_before + 1) begin
        failures++;
        $display("FAIL run_start_pulses got %0d expected 1", run_start_cnt - rs_before);
      end
      checks++;
      if (loaded_count !== (AW+1)'(exp_cnt)) begin
        failures++;
        $display("FAIL loaded_count got %0d expected %0d", loaded_count, exp_cnt);
      end
      exp_loaded = exp_cnt;
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL missing_writes got %0d pending expected 0", exp_q.size());
      end
      // run_done during the START cycle must be ignored.
      run_done = 1'b1;
      tick();
      run_done = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL run_wait got busy=%b in_ready=%b expected busy=1 in_ready=0", busy, in_ready);
      end
      run_done = 1'b1;
      tick();
      run_done = 1'b0;
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b1 || error !== 1'b0) begin
        failures++;
        $display("FAIL run_end got busy=%b in_ready=%b error=%b expected 0 1 0", busy, in_ready, error);
      end
    end else begin
      repeat (3) tick();
      checks++;
      if (error !== 1'b1 || error_code !== exp_err) begin
        failures++;
        $display("FAIL error_state got error=%b code=%0d expected 1 %0d", error, error_code, exp_err);
      end
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL error_ready got in_ready=%b busy=%b expected 0 1", in_ready, busy);
      end
      checks++;
      if (run_start_cnt != rs_before) begin
        failures++;
        $display("FAIL error_no_start got %0d pulses expected 0", run_start_cnt - rs_before);
      end
      checks++;
      if (loaded_count !== (AW+1)'(exp_loaded)) begin
        failures++;
        $display("FAIL error_loaded got %0d expected %0d", loaded_count, exp_loaded);
      end
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL error_writes got %0d pending expected 0", exp_q.size());
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || error !== 1'b0 || error_code !== 2'd0 ||
        mem_we !== 1'b0 || run_start !== 1'b0 || loaded_count !== '0) begin
      failures++;
      $display("FAIL %s got rdy=%b busy=%b err=%b code=%0d we=%b start=%b loaded=%0d expected 1 0 0 0 0 0 0",
               tag, in_ready, busy, error, error_code, mem_we, run_start, loaded_count);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    check_idle_outputs("reset_outputs");
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      failures++;
      $display("FAIL reset_mem got addr=%0h data=%08h expected 0 0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_single();
    words.delete();
    words.push_back(32'h04030201);
    build_frame(1, 1'b0, 8'h00);
    for (int k = 0; k < 6; k++) send_byte(frame_q[k], 1'b0);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 32'h04030201) begin
      failures++;
      $display("FAIL single_write_latency got we=%b addr=%0h data=%08h expected 1 0 04030201",
               mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if (frame_q[6] !== 8'h05) begin
      failures++;
      $display("FAIL single_checksum got %02h expected 05", frame_q[6]);
    end
    send_byte(frame_q[6], 1'b0);
    finish_frame();
  endtask

  task automatic test_zero();
    words.delete();
    build_frame(0, 1'b0, 8'h00);
    send_frame(1'b0);
    finish_frame();
  endtask

  task automatic test_random();
    int cnt;
    for (int f = 0; f < 4; f++) begin
      cnt = $urandom_range(1, 8);
      words.delete();
      for (int i = 0; i < cnt; i++) words.push_back($urandom);
      build_frame(cnt, 1'b0, 8'h00);
      send_frame(1'b1);
      finish_frame();
    end
  endtask

  task automatic test_bad_checksum();
    words.delete();
    words.push_back(32'h11111111);
    words.push_back(32'h22222222);
    build_frame(2, 1'b1, 8'hFF);
    send_frame(1'b0);
    finish_frame();
    do_reset();
  endtask

  task automatic test_count_large();
    words.delete();
    build_frame(257, 1'b0, 8'h00);
    send_frame(1'b0);
    finish_frame();
    repeat (20) tick();
    checks++;
    if (in_ready !== 1'b0 || error !== 1'b1 || error_code !== ERR_COUNT) begin
      failures++;
      $display("FAIL error_sticky got rdy=%b err=%b code=%0d expected 0 1 1", in_ready, error, error_code);
    end
    do_reset();
    check_idle_outputs("error_cleared");
  endtask

  task automatic test_full();
    words.delete();
    for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
    build_frame(DEPTH, 1'b0, 8'h00);
    send_frame(1'b1);
    finish_frame();
  endtask

  task automatic test_reset_mid();
    words.delete();
    words.push_back($urandom);
    words.push_back($urandom);
    build_frame(2, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) send_byte(frame_q[k], 1'b0);
    do_reset();
    check_idle_outputs("reset_mid_frame");
    words.delete();
    words.push_back($urandom);
    build_frame(1, 1'b0, 8'h00);
    send_frame(1'b1);
    finish_frame();
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_random();
    test_bad_checksum();
    test_count_large();
    test_full();
    test_reset_mid();
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpga_program_loader.md
Name: fpga_program_loader

Overview:
- Producer side of the test-program interface: streams a program into the instruction memory that the fpga test executor fetches from, then starts the executor and waits for it to finish.
- Input is a byte stream with a valid/ready handshake from the host link.
- Each frame is: 16-bit instruction count, little-endian instruction words, XOR checksum byte.
- Sits between the host byte link and the executor's instruction memory write port plus its run/done handshake.

Parameters:
- INSTR_WIDTH, 32, instruction word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, instruction memory address width; DEPTH = 2**ADDR_WIDTH.
- BYTES, INSTR_WIDTH/8, bytes per instruction (localparam, derived).

Ports:
- clock  input  1  driving clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  byte available.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write strobe.
- mem_addr  output  ADDR_WIDTH  write address.
- mem_wdata  output  INSTR_WIDTH  write data.
- run_start  output  1  one-cycle pulse that starts the executor.
- run_done  input  1  executor finished; level or pulse, sampled only in RUN.
- busy  output  1  high in any state other than LEN_LO.
- error  output  1  sticky error flag.
- error_code  output  2  0 none, 1 count too large, 2 checksum mismatch.
- loaded_count  output  ADDR_WIDTH+1  instructions written by the last accepted frame.

Behaviour:
- Byte accept: in_valid && in_ready at posedge. in_data is don't-care otherwise.
- Reset values, registered: state=LEN_LO, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, run_start=0, busy=0, error=0, error_code=0, loaded_count=0. Also cleared: byte index, word index, checksum accumulator, count register.
- in_ready is 1 in LEN_LO, LEN_HI, DATA and CHECK; 0 in START, RUN and ERROR.
- Every accepted byte except the checksum byte is XORed into the accumulator. The accumulator clears on entry to LEN_LO.
- State transitions:
  - LEN_LO: accept byte into count[7:0] -> LEN_HI.
  - LEN_HI: accept byte into count[15:8]. Then:
    - if count > DEPTH -> ERROR with code 1;
    - else if count == 0 -> CHECK;
    - else -> DATA, with word index 0 and byte index 0.
  - DATA: each accepted byte fills lane byte_index of the word (little-endian, lane 0 first).
    - On the accept of byte BYTES-1: next cycle mem_we=1 for exactly one cycle, mem_addr=word_index, mem_wdata=assembled word. Write latency is 1 cycle after the last byte.
    - Word index increments after each completed word.
    - After word count-1 completes -> CHECK. The final write strobe overlaps the first CHECK cycle.
  - CHECK: accept byte.
    - If it equals the accumulator: loaded_count=count and -> START.
    - Otherwise -> ERROR with code 2; loaded_count is unchanged.
  - START: run_start=1 for one cycle -> RUN.
  - RUN: wait for run_done=1 -> LEN_LO. A run_done seen in the START cycle is ignored.
  - ERROR: sticky; only reset exits. error=1 and error_code hold their values.
- Full-memory boundary: count == DEPTH is legal and writes addresses 0..DEPTH-1. Because mem_addr is ADDR_WIDTH wide, the word index must be ADDR_WIDTH+1 bits wide so the termination compare is correct.
- Memory writes are not rolled back on a checksum error. The executor is never started for a bad frame.
- Reset mid-frame or mid-run:
  - Immediate return to LEN_LO, all outputs at their reset values.
  - The partially written memory contents are left as they are.
  - An executor that is already running is not signalled.
- mem_we and run_start are never high in the same cycle.

Decomposition:
- Package fpga_loader_pkg holds:
  - the state enum (LEN_LO, LEN_HI, DATA, CHECK, START, RUN, ERROR);
  - the error code constants (ERR_NONE=0, ERR_COUNT=1, ERR_CHECKSUM=2).
- One natural sub-module, fpga_word_assembler: byte-lane shift/assemble with byte index and word-complete pulse, parameterized by BYTES.
- The FSM, checksum and addressing stay in the top module.

Test Plan:
- count=1, word 0x04030201: send 01 00 01 02 03 04 05.
  - Expect one write: addr 0, data 0x04030201, 1 cycle after byte 04.
  - Then run_start pulse, loaded_count=1.
  - Drive run_done -> busy=0, in_ready=1.
- count=0: send 00 00 00 -> no mem_we, run_start pulses, loaded_count=0.
- count=257 with ADDR_WIDTH=8: send 01 01 -> ERROR after 2nd byte, error_code=1, in_ready=0 until reset.
- count=2, words 0x11111111 and 0x22222222, wrong checksum 0xFF (correct is 0x02):
  - Expect both writes (addr 0, 1), then error_code=2, no run_start.
  - loaded_count keeps its previous value.
- count=256 (00 01), with in_valid toggled randomly:
  - Expect 256 writes, addr 0..255 in order, no lost or duplicated bytes, then run_start.
- Assert reset after byte 3 of a count=2 frame, then send a full valid count=1 frame:
  - Expect a clean restart: single write at addr 0 and run_start.
